// File: rtl/gate_eval_pkg.sv
// Shared encodings for the gate-evaluation arbiter: reduction opcodes and FSM states.
package gate_eval_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_NAND = 2'b01,
    OP_XOR  = 2'b10,
    OP_OR   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EVAL = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/gate_reduce8.sv
// Combinational 8-input reduction unit: and8/nand8/xor8/or8 cells behind a 4:1 opcode select.
module and8 (
  input  logic [7:0] a,
  output logic       y
);
  assign y = &a;
endmodule

module nand8 (
  input  logic [7:0] a,
  output logic       y
);
  assign y = ~&a;
endmodule

module xor8 (
  input  logic [7:0] a,
  output logic       y
);
  assign y = ^a;
endmodule

module or8 (
  input  logic [7:0] a,
  output logic       y
);
  assign y = |a;
endmodule

module gate_reduce8
  import gate_eval_pkg::*;
(
  input  logic [1:0] op,
  input  logic [7:0] data,
  output logic       result
);

  logic and_s;
  logic nand_s;
  logic xor_s;
  logic or_s;

  and8  u_and8  (.a(data), .y(and_s));
  nand8 u_nand8 (.a(data), .y(nand_s));
  xor8  u_xor8  (.a(data), .y(xor_s));
  or8   u_or8   (.a(data), .y(or_s));

  // Opcode select across the four cell outputs.
  always_comb begin
    result = 1'b0;
    case (op)
      OP_AND:  result = and_s;
      OP_NAND: result = nand_s;
      OP_XOR:  result = xor_s;
      OP_OR:   result = or_s;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_eval_arbiter.sv
// NREQ requesters time-share one gate_reduce8 unit through an IDLE/EVAL/RESP FSM.
// Define GATE_EVAL_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module gate_eval_arbiter
  import gate_eval_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [2*NREQ-1:0] req_op,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_result,
  input  logic              rsp_ready
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             result_q, result_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0]  req_ready_s;
  logic             grant_found_s;
  logic [IDW-1:0]   grant_id_s;
  logic             reduce_result_s;
  logic [1:0]       op_arr_s   [NREQ];
  logic [7:0]       data_arr_s [NREQ];

`ifdef GATE_EVAL_RR_EN
  logic [IDW-1:0]   ptr_q, ptr_d;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr_s[g]   = req_op[2*g+1:2*g];
    assign data_arr_s[g] = req_data[8*g+7:8*g];
  end

  gate_reduce8 u_reduce (
    .op     (op_q),
    .data   (data_q),
    .result (reduce_result_s)
  );

  // Winner search: rotating start after the pointer, or plain lowest index.
  always_comb begin
    logic [IDW:0] sum;
    logic [IDW-1:0] idx;
    sum           = '0;
    idx           = '0;
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef GATE_EVAL_RR_EN
      sum = {1'b0, ptr_q} + (IDW+1)'(1) + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end else begin
        sum = sum;
      end
      idx = sum[IDW-1:0];
`else
      sum = (IDW+1)'(k);
      idx = sum[IDW-1:0];
`endif
      if (!grant_found_s && req_valid[idx]) begin
        grant_found_s = 1'b1;
        grant_id_s    = idx;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // FSM next state, operand capture and response generation.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    id_d        = id_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;
    req_ready_s = '0;
`ifdef GATE_EVAL_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Grants are suppressed while reset is held so req_ready reads zero.
        if (grant_found_s && !rst) begin
          req_ready_s[grant_id_s] = 1'b1;
          op_d    = op_arr_s[grant_id_s];
          data_d  = data_arr_s[grant_id_s];
          id_d    = grant_id_s;
          state_d = ST_EVAL;
`ifdef GATE_EVAL_RR_EN
          ptr_d   = grant_id_s;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        result_d    = reduce_result_s;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      data_q      <= 8'h00;
      id_q        <= '0;
      result_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
`ifdef GATE_EVAL_RR_EN
      ptr_q       <= IDW'(NREQ-1);
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      id_q        <= id_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
`ifdef GATE_EVAL_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign req_ready  = req_ready_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Directed self-checking bench for gate_eval_arbiter (NREQ=4); expectations follow GATE_EVAL_RR_EN.
module tb_gate_eval_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic        rsp_result;
  logic        rsp_ready;

  int checks   = 0;
  int failures = 0;

  gate_eval_arbiter #(.NREQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transaction for requester id, optionally with other requesters also valid.
  task automatic do_op(input string tag, input int id, input logic [1:0] op,
                       input logic [7:0] data, input logic exp_res, input logic [3:0] extra);
    req_op[2*id +: 2]   = op;
    req_data[8*id +: 8] = data;
    req_valid = (4'b0001 << id) | extra;
    rsp_ready = 1'b1;
    #1;
    chk({tag, "_grant"}, 32'(req_ready), 32'(4'b0001 << id));
    @(posedge clk); #1;
    req_valid = 4'b0000;
    #1;
    chk({tag, "_eval_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_eval_valid"}, 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 32'(id));
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'(exp_res));
    @(posedge clk); #1;
    chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int last;
    int exp_ids [5];
    int exp_res [5];
`ifdef GATE_EVAL_RR_EN
    exp_ids = '{0, 1, 2, 3, 0};
    exp_res = '{0, 1, 0, 1, 0};
`else
    exp_ids = '{0, 0, 0, 0, 0};
    exp_res = '{0, 0, 0, 0, 0};
`endif

    rst       = 1'b1;
    req_valid = 4'b0000;
    req_op    = 8'h00;
    req_data  = 32'h0;
    rsp_ready = 1'b0;
    #2;
    req_valid = 4'b1111;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    req_valid = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("idle_no_req_ready", 32'(req_ready), 32'd0);

    // Single XOR request: B7 has six ones.
    do_op("single", 0, 2'b10, 8'hB7, 1'b0, 4'b0000);

    // Opcodes on all-ones and all-zeros.
    do_op("and_ff",  2, 2'b00, 8'hFF, 1'b1, 4'b0000);
    do_op("nand_ff", 2, 2'b01, 8'hFF, 1'b0, 4'b0000);
    do_op("xor_ff",  2, 2'b10, 8'hFF, 1'b0, 4'b0000);
    do_op("or_ff",   2, 2'b11, 8'hFF, 1'b1, 4'b0000);
    do_op("and_00",  2, 2'b00, 8'h00, 1'b0, 4'b0000);
    do_op("nand_00", 2, 2'b01, 8'h00, 1'b1, 4'b0000);
    do_op("xor_00",  2, 2'b10, 8'h00, 1'b0, 4'b0000);
    do_op("or_00",   2, 2'b11, 8'h00, 1'b0, 4'b0000);
    do_op("xor_01",  3, 2'b10, 8'h01, 1'b1, 4'b0000);

    // Continuous contention: all OR, data per requester 00/01/00/80.
    req_op    = 8'hFF;
    req_data  = {8'h80, 8'h00, 8'h01, 8'h00};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    n    = 0;
    last = 0;
    for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin
        chk($sformatf("arb_id_%0d", n), 32'(rsp_id), 32'(exp_ids[n]));
        chk($sformatf("arb_res_%0d", n), 32'(rsp_result), 32'(exp_res[n]));
        if (n > 0) chk($sformatf("arb_gap_%0d", n), 32'(cyc - last), 32'd3);
        last = cyc;
        n++;
      end
    end
    req_valid = 4'b0000;
    chk("arb_count", 32'(n), 32'd5);
    @(posedge clk); #1;
    chk("arb_drain_valid", 32'(rsp_valid), 32'd0);
    chk("arb_drain_ready", 32'(req_ready), 32'd0);

    // Backpressure: requester 1 AND on FF held in RESP for five cycles.
    req_op[2 +: 2]  = 2'b00;
    req_data[8 +: 8] = 8'hFF;
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    #1;
    chk("bp_eval_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_id_%0d", i), 32'(rsp_id), 32'd1);
      chk($sformatf("bp_res_%0d", i), 32'(rsp_result), 32'd1);
      chk($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", 32'(rsp_valid), 32'd1);
    chk("bp_release_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("bp_idle_valid", 32'(rsp_valid), 32'd0);
`ifdef GATE_EVAL_RR_EN
    chk("bp_next_grant", 32'(req_ready), 32'h4);
`else
    chk("bp_next_grant", 32'(req_ready), 32'h1);
`endif
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(posedge clk); #1;
`ifdef GATE_EVAL_RR_EN
    chk("bp_next_id", 32'(rsp_id), 32'd2);
`else
    chk("bp_next_id", 32'(rsp_id), 32'd0);
`endif
    chk("bp_next_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;

    // Reset during EVAL: requester 2 OR on FF is dropped.
    req_op[4 +: 2]    = 2'b11;
    req_data[16 +: 8] = 8'hFF;
    req_valid = 4'b0100;
    #1;
    chk("rst_op_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("rst_eval_ready", 32'(req_ready), 32'd0);
    chk("rst_eval_valid", 32'(rsp_valid), 32'd0);
    chk("rst_eval_id", 32'(rsp_id), 32'd0);
    chk("rst_eval_result", 32'(rsp_result), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_no_rsp_%0d", i), 32'(rsp_valid), 32'd0);
    end
    do_op("post_rst", 1, 2'b10, 8'h07, 1'b1, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
